spram_bwe_clr: RTL and testbench

Parametrised single-port synchronous RAM. It is the successor to the fixed 32x1024 single-port RAM IP.
- Adds per-byte write enables and a selectable read-during-write mode.
- Adds a configurable output pipeline (1 or 2 cycles) with a read-valid flag.
- Adds a hardware clear sequencer that zeroes the array after reset and reports rsta_busy.
- Used as generic on-chip buffer/coefficient storage behind a simple ena/wea/addra port.

---
 rtl/spram_bwe_clr_if.sv | 27 ++
 rtl/spram_bwe_clr.sv | 158 +++++++++++++++
 tb/tb_spram_bwe_clr.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spram_bwe_clr_if.sv
// rtl/spram_bwe_clr_if.sv - access port bundle for spram_bwe_clr
// Ports:
//   ena, wea, addra, dina       requester -> RAM (access enable, byte-lane write enables, address, write data)
//   douta, douta_vld, rsta_busy RAM -> requester (read data, read-valid pulse, reset/clear busy)
interface spram_bwe_clr_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR   = 10,
   parameter int NB_COL = WIDTH / 8
);
   logic              ena;
   logic [NB_COL-1:0] wea;
   logic [ADDR-1:0]   addra;
   logic [WIDTH-1:0]  dina;
   logic [WIDTH-1:0]  douta;
   logic              douta_vld;
   logic              rsta_busy;

   modport master (
      output ena, wea, addra, dina,
      input  douta, douta_vld, rsta_busy
   );

   modport slave (
      input  ena, wea, addra, dina,
      output douta, douta_vld, rsta_busy
   );
endinterface

// File: rtl/spram_bwe_clr.sv
// rtl/spram_bwe_clr.sv - single-port RAM with byte write enables, read pipeline and clear sequencer
// Ports:
//   clka  clock, rising edge
//   rsta  asynchronous active-low reset
//   bus   spram_bwe_clr_if.slave: ena/wea/addra/dina in, douta/douta_vld/rsta_busy out
module spram_bwe_clr #(
   parameter int               WIDTH          = 32,
   parameter int               DEPTH          = 1024,
   parameter int               ADDR           = $clog2(DEPTH),
   parameter int               NB_COL         = WIDTH / 8,
   parameter int               WRITE_MODE     = 0,
   parameter int               READ_LATENCY   = 1,
   parameter int               CLEAR_ON_RESET = 1,
   parameter logic [WIDTH-1:0] CLEAR_VALUE    = '0
) (
   input logic            clka,
   input logic            rsta,
   spram_bwe_clr_if.slave bus
);

   generate
      if (WIDTH % 8 != 0) begin : g_bad_width
         $error("spram_bwe_clr: WIDTH must be a multiple of 8");
      end
      if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
         $error("spram_bwe_clr: READ_LATENCY must be 1 or 2");
      end
      if (WRITE_MODE < 0 || WRITE_MODE > 2) begin : g_bad_mode
         $error("spram_bwe_clr: WRITE_MODE must be 0, 1 or 2");
      end
   endgenerate

   // One extra bit so DEPTH itself is representable when DEPTH is a power of two
   localparam logic [ADDR:0]   DEPTH_W  = (ADDR + 1)'(DEPTH);
   localparam logic [ADDR-1:0] LAST_IDX = ADDR'(DEPTH - 1);

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t           state_q, state_d;
   logic [ADDR-1:0]  cnt_q, cnt_d;
   logic             clr_we;
   logic             busy_q;
   logic             acc;
   logic             in_range;
   logic             wr_en;
   logic [WIDTH-1:0] old_word;
   logic [WIDTH-1:0] merged;
   logic [WIDTH-1:0] s1_data_q;
   logic             s1_vld_q;
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clka or negedge rsta) begin
      if (!rsta) begin
         state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         // Registered so busy drops on the same edge that enters READY
         busy_q  <= (state_d != ST_READY);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clr_we = 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = ST_READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_READY;
         end
      endcase
   end

   assign in_range = ({1'b0, bus.addra} < DEPTH_W);
   assign acc      = bus.ena && !busy_q;
   assign wr_en    = acc && in_range && (bus.wea != '0);
   assign old_word = in_range ? mem[bus.addra] : '0;

   // Word as it will look after this write; out-of-range accesses always read as zero
   always_comb begin
      merged = '0;
      if (in_range) begin
         for (int i = 0; i < NB_COL; i++) begin
            merged[8*i +: 8] = bus.wea[i] ? bus.dina[8*i +: 8] : old_word[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clka) begin
      if (clr_we) begin
         mem[cnt_q] <= CLEAR_VALUE;
      end else if (wr_en) begin
         for (int i = 0; i < NB_COL; i++) begin
            if (bus.wea[i]) begin
               mem[bus.addra][8*i +: 8] <= bus.dina[8*i +: 8];
            end
         end
      end
   end

   // Stage 1: holds its data unless a result is produced, so douta only moves on valid
   always_ff @(posedge clka or negedge rsta) begin
      if (!rsta) begin
         s1_data_q <= '0;
         s1_vld_q  <= 1'b0;
      end else begin
         s1_vld_q <= 1'b0;
         if (acc) begin
            if (bus.wea == '0 || WRITE_MODE == 0) begin
               s1_data_q <= old_word;
               s1_vld_q  <= 1'b1;
            end else if (WRITE_MODE == 1) begin
               s1_data_q <= merged;
               s1_vld_q  <= 1'b1;
            end
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic [WIDTH-1:0] s2_data_q;
         logic             s2_vld_q;

         always_ff @(posedge clka or negedge rsta) begin
            if (!rsta) begin
               s2_data_q <= '0;
               s2_vld_q  <= 1'b0;
            end else begin
               s2_vld_q <= s1_vld_q;
               if (s1_vld_q) begin
                  s2_data_q <= s1_data_q;
               end
            end
         end

         assign bus.douta     = s2_data_q;
         assign bus.douta_vld = s2_vld_q;
      end else begin : g_lat1
         assign bus.douta     = s1_data_q;
         assign bus.douta_vld = s1_vld_q;
      end
   endgenerate

   assign bus.rsta_busy = busy_q;

endmodule

// File: tb/tb_spram_bwe_clr.sv
// tb/tb_spram_bwe_clr.sv - self-checking bench for spram_bwe_clr (four parameter sets)
module tb_spram_bwe_clr;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spram_bwe_clr_if #(.WIDTH(32), .ADDR(10)) if0 ();
   spram_bwe_clr_if #(.WIDTH(32), .ADDR(10)) if1 ();
   spram_bwe_clr_if #(.WIDTH(32), .ADDR(6))  if2 ();
   spram_bwe_clr_if #(.WIDTH(32), .ADDR(4))  if3 ();

   spram_bwe_clr #(.DEPTH(1024), .WRITE_MODE(0), .READ_LATENCY(1), .CLEAR_ON_RESET(1))
      u0 (.clka(clk), .rsta(rst_n), .bus(if0));
   spram_bwe_clr #(.DEPTH(1000), .WRITE_MODE(1), .READ_LATENCY(2), .CLEAR_ON_RESET(1))
      u1 (.clka(clk), .rsta(rst_n), .bus(if1));
   spram_bwe_clr #(.DEPTH(64), .WRITE_MODE(2), .READ_LATENCY(1), .CLEAR_ON_RESET(1),
                   .CLEAR_VALUE(32'hDEADBEEF))
      u2 (.clka(clk), .rsta(rst_n), .bus(if2));
   spram_bwe_clr #(.DEPTH(16), .WRITE_MODE(0), .READ_LATENCY(2), .CLEAR_ON_RESET(0))
      u3 (.clka(clk), .rsta(rst_n), .bus(if3));

   function automatic int dep(input int k);
      case (k) 0: return 1024; 1: return 1000; 2: return 64; default: return 16; endcase
   endfunction
   function automatic int wm(input int k);
      case (k) 0: return 0; 1: return 1; 2: return 2; default: return 0; endcase
   endfunction
   function automatic int rl(input int k);
      return (k == 1 || k == 3) ? 2 : 1;
   endfunction
   function automatic bit cor(input int k);
      return (k != 3);
   endfunction
   function automatic logic [31:0] cv(input int k);
      return (k == 2) ? 32'hDEADBEEF : 32'h0;
   endfunction
   function automatic int aw(input int k);
      case (k) 0: return 10; 1: return 10; 2: return 6; default: return 4; endcase
   endfunction

   logic        s_en [4];
   logic [3:0]  s_we [4];
   logic [9:0]  s_a  [4];
   logic [31:0] s_d  [4];

   logic [31:0] o_d [4];
   logic        o_v [4];
   logic        o_b [4];
   assign o_d[0] = if0.douta; assign o_v[0] = if0.douta_vld; assign o_b[0] = if0.rsta_busy;
   assign o_d[1] = if1.douta; assign o_v[1] = if1.douta_vld; assign o_b[1] = if1.rsta_busy;
   assign o_d[2] = if2.douta; assign o_v[2] = if2.douta_vld; assign o_b[2] = if2.rsta_busy;
   assign o_d[3] = if3.douta; assign o_v[3] = if3.douta_vld; assign o_b[3] = if3.rsta_busy;

   // Reference model: word array, known-content flags, results scheduled by due slot
   logic [31:0] mm [4][1024];
   bit          kn [4][1024];
   bit          ev [4][4];
   bit          ek [4][4];
   logic [31:0] ed [4][4];
   logic [31:0] last [4];
   bit          lk [4];
   int          clr_left [4];
   bit          in_reset;
   int          t;
   int          n_chk;
   int          n_err;

   typedef struct packed {
      logic        en;
      logic [3:0]  we;
      logic [9:0]  a;
      logic [31:0] d;
      logic        xv;
      logic [31:0] xd;
   } vec_t;

   vec_t tv [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      for (int k = 0; k < 4; k++) begin
         s_en[k] = 1'b0; s_we[k] = 4'h0; s_a[k] = 10'd0; s_d[k] = 32'h0;
      end
   endtask

   task automatic drive();
      if0.ena = s_en[0]; if0.wea = s_we[0]; if0.addra = s_a[0];      if0.dina = s_d[0];
      if1.ena = s_en[1]; if1.wea = s_we[1]; if1.addra = s_a[1];      if1.dina = s_d[1];
      if2.ena = s_en[2]; if2.wea = s_we[2]; if2.addra = s_a[2][5:0]; if2.dina = s_d[2];
      if3.ena = s_en[3]; if3.wea = s_we[3]; if3.addra = s_a[3][3:0]; if3.dina = s_d[3];
   endtask

   task automatic sched(input int k, input logic [31:0] d, input bit known);
      int s;
      s = (t + rl(k)) % 4;
      ev[k][s] = 1'b1; ed[k][s] = d; ek[k][s] = known;
   endtask

   task automatic model_apply(input int k);
      int          a;
      bit          inr;
      bit          ok;
      logic [31:0] old;
      logic [31:0] nw;
      if (!s_en[k] || in_reset || clr_left[k] != 0) return;
      a   = int'(s_a[k]) & ((1 << aw(k)) - 1);
      inr = (a < dep(k));
      old = inr ? mm[k][a] : 32'h0;
      ok  = inr ? kn[k][a] : 1'b1;
      nw  = old;
      for (int i = 0; i < 4; i++) if (s_we[k][i]) nw[8*i +: 8] = s_d[k][8*i +: 8];
      if (inr && s_we[k] != 4'h0) begin
         mm[k][a] = nw;
         kn[k][a] = ok || (s_we[k] == 4'hF);
      end
      if (s_we[k] == 4'h0 || wm(k) == 0) sched(k, old, ok);
      else if (wm(k) == 1) sched(k, inr ? nw : 32'h0, inr ? (ok || s_we[k] == 4'hF) : 1'b1);
   endtask

   task automatic model_check();
      int s;
      bit v;
      s = t % 4;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("u%0d busy t=%0d", k, t), 32'(o_b[k]), 32'(in_reset || clr_left[k] > 0));
         v = ev[k][s];
         if (v) begin
            last[k] = ed[k][s]; lk[k] = ek[k][s]; ev[k][s] = 1'b0;
         end
         chk($sformatf("u%0d vld t=%0d", k, t), 32'(o_v[k]), 32'(v));
         if (lk[k]) chk($sformatf("u%0d douta t=%0d", k, t), o_d[k], last[k]);
      end
   endtask

   task automatic step();
      drive();
      for (int k = 0; k < 4; k++) model_apply(k);
      @(posedge clk);
      t++;
      for (int k = 0; k < 4; k++) if (!in_reset && clr_left[k] > 0) clr_left[k]--;
      @(negedge clk);
      model_check();
   endtask

   task automatic assert_rst();
      rst_n = 1'b0;
      in_reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         last[k] = 32'h0; lk[k] = 1'b1; clr_left[k] = 0;
         for (int s = 0; s < 4; s++) ev[k][s] = 1'b0;
      end
   endtask

   task automatic release_rst();
      rst_n = 1'b1;
      in_reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         clr_left[k] = cor(k) ? dep(k) : 1;
         if (cor(k)) for (int a = 0; a < 1024; a++) begin mm[k][a] = cv(k); kn[k][a] = 1'b1; end
      end
   endtask

   task automatic set_acc(input int k, input logic en, input logic [3:0] we,
                          input logic [9:0] a, input logic [31:0] d);
      s_en[k] = en; s_we[k] = we; s_a[k] = a; s_d[k] = d;
   endtask

   initial begin
      #10ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          fall [4];
      int          r;
      int          a;
      logic [31:0] exp_rd [5];

      n_chk = 0; n_err = 0; t = 0;
      for (int k = 0; k < 4; k++) for (int i = 0; i < 1024; i++) begin mm[k][i] = 32'h0; kn[k][i] = 1'b0; end
      idle();
      assert_rst();
      repeat (3) step();
      chk("reset busy u0", 32'(o_b[0]), 32'h1);
      chk("reset vld u1", 32'(o_v[1]), 32'h0);
      chk("reset douta u2", o_d[2], 32'h0);

      // Clear aborted part-way by a second reset; the restart must take the full depth
      release_rst();
      repeat (300) step();
      assert_rst();
      repeat (2) step();
      release_rst();
      for (int k = 0; k < 4; k++) fall[k] = -1;
      for (int i = 0; i < 1100; i++) begin
         if (i == 4) set_acc(0, 1'b1, 4'hF, 10'd9, 32'hFFFFFFFF);
         else idle();
         step();
         for (int k = 0; k < 4; k++) if (fall[k] < 0 && !o_b[k]) fall[k] = i + 1;
      end
      for (int k = 0; k < 4; k++) chk($sformatf("u%0d busy fall cycles", k), fall[k], cor(k) ? dep(k) : 1);

      // Directed table on the READ_FIRST, latency-1 instance
      tv[0]  = '{1'b1, 4'h0, 10'd0,    32'h0,        1'b1, 32'h00000000};
      tv[1]  = '{1'b1, 4'h0, 10'd511,  32'h0,        1'b1, 32'h00000000};
      tv[2]  = '{1'b1, 4'h0, 10'd1023, 32'h0,        1'b1, 32'h00000000};
      tv[3]  = '{1'b1, 4'h0, 10'd9,    32'h0,        1'b1, 32'h00000000};
      tv[4]  = '{1'b1, 4'hF, 10'd5,    32'hAABBCCDD, 1'b1, 32'h00000000};
      tv[5]  = '{1'b1, 4'h2, 10'd5,    32'h11223344, 1'b1, 32'hAABBCCDD};
      tv[6]  = '{1'b1, 4'h0, 10'd5,    32'h0,        1'b1, 32'hAABB33DD};
      tv[7]  = '{1'b1, 4'hF, 10'd7,    32'h3,        1'b1, 32'h00000000};
      tv[8]  = '{1'b1, 4'hF, 10'd7,    32'h5,        1'b1, 32'h00000003};
      tv[9]  = '{1'b1, 4'h0, 10'd7,    32'h0,        1'b1, 32'h00000005};
      tv[10] = '{1'b0, 4'h0, 10'd0,    32'h0,        1'b0, 32'h00000005};
      tv[11] = '{1'b0, 4'hF, 10'd7,    32'h0,        1'b0, 32'h00000005};
      tv[12] = '{1'b1, 4'h0, 10'd7,    32'h0,        1'b1, 32'h00000005};
      idle();
      for (int i = 0; i < 13; i++) begin
         set_acc(0, tv[i].en, tv[i].we, tv[i].a, tv[i].d);
         step();
         chk($sformatf("table %0d vld", i), 32'(o_v[0]), 32'(tv[i].xv));
         chk($sformatf("table %0d douta", i), o_d[0], tv[i].xd);
      end

      // NO_CHANGE: writes leave douta alone and raise no valid
      idle();
      set_acc(2, 1'b1, 4'h0, 10'd1, 32'h0); step();
      chk("nc clear read vld", 32'(o_v[2]), 32'h1);
      chk("nc clear read data", o_d[2], 32'hDEADBEEF);
      set_acc(2, 1'b1, 4'hF, 10'd7, 32'h3); step();
      set_acc(2, 1'b1, 4'hF, 10'd7, 32'h5); step();
      chk("nc write vld", 32'(o_v[2]), 32'h0);
      chk("nc write douta held", o_d[2], 32'hDEADBEEF);
      set_acc(2, 1'b1, 4'h0, 10'd7, 32'h0); step();
      chk("nc readback vld", 32'(o_v[2]), 32'h1);
      chk("nc readback data", o_d[2], 32'h5);

      // WRITE_FIRST, latency 2, depth 1000
      idle();
      for (int i = 0; i < 4; i++) begin
         set_acc(1, 1'b1, 4'hF, 10'(i), 32'(100 + i)); step();
      end
      set_acc(1, 1'b1, 4'hF, 10'd7, 32'h3); step();
      set_acc(1, 1'b1, 4'hF, 10'd7, 32'h5); step();
      idle(); step();
      chk("wf merged vld", 32'(o_v[1]), 32'h1);
      chk("wf merged data", o_d[1], 32'h5);
      set_acc(1, 1'b1, 4'hF, 10'd1010, 32'hFFFFFFFF); step();
      exp_rd[0] = 32'd100; exp_rd[1] = 32'd101; exp_rd[2] = 32'd102; exp_rd[3] = 32'd103; exp_rd[4] = 32'h0;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) set_acc(1, 1'b1, 4'h0, 10'(i), 32'h0);
         else if (i == 4) set_acc(1, 1'b1, 4'h0, 10'd1010, 32'h0);
         else idle();
         step();
         if (i >= 1) begin
            chk($sformatf("lat2 b2b vld %0d", i), 32'(o_v[1]), 32'h1);
            chk($sformatf("lat2 b2b data %0d", i), o_d[1], exp_rd[i-1]);
         end
      end
      idle(); step();
      chk("lat2 tail vld", 32'(o_v[1]), 32'h0);
      chk("lat2 tail douta held", o_d[1], 32'h0);

      // Random traffic on all instances against the model
      for (int n = 0; n < 3000; n++) begin
         for (int k = 0; k < 4; k++) begin
            r = int'($urandom_range(0, 3));
            if (r == 0) a = int'($urandom_range(0, (1 << aw(k)) - 1));
            else if (r == 1) a = dep(k) - 4 + int'($urandom_range(0, 7));
            else a = int'($urandom_range(0, 7));
            a = a & ((1 << aw(k)) - 1);
            s_en[k] = ($urandom_range(0, 9) < 7);
            s_we[k] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
            s_a[k]  = 10'(a);
            s_d[k]  = $urandom;
         end
         step();
      end
      idle();
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
